sdf_stage_ctrl: RTL and testbench

Sequencing controller for one radix-2 single-delay-feedback (SDF) stage of the 32-point FFT pipeline. It accepts the stage's input stream with a valid/ready handshake and counts samples within each 2·DELAY-sample frame. It drives the butterfly mode, shift-register enable, twiddle index and registered data/valid to the butterfly and feedback shift register. It also drains the shift register on request so the last frame's difference terms leave the stage without needing a following frame.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_sample_cnt.sv | 37 +++
 rtl/sdf_stage_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the SDF FFT stage controllers: datapath widths,
// butterfly mode encodings, the stage FSM state type and the twiddle-index
// helper.
// Ports: none (package).
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int TW_W   = 4;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_BFLY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BFLY  = 2'd2,
        ST_DRAIN = 2'd3
    } stage_state_t;

    // k = offset * step, kept modulo 2^TW_W (W32^k repeats every 32, and
    // the index only ever spans one half-turn).
    function automatic logic [TW_W-1:0] tw_index(input int unsigned off,
                                                 input int unsigned step);
        return TW_W'(off * step);
    endfunction

endpackage

// File: rtl/fft_sample_cnt.sv
// fft_sample_cnt
// Enable-driven modulo-2*DELAY sample counter for one SDF stage.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   en           advance the counter by one (one accepted sample)
//   cnt          position of the next sample within the frame
//   half         cnt >= DELAY (second half of the frame)
//   wrap         en while cnt is on the last sample of the frame
module fft_sample_cnt
    import fft_pkg::*;
#(
    parameter int DELAY = 16,
    parameter int CNT_W = $clog2(2 * DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             half,
    output logic             wrap
);

    logic last;

    assign last = (cnt == CNT_W'(2 * DELAY - 1));
    assign half = (cnt >= CNT_W'(DELAY));
    assign wrap = en && last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl
// Sequencing controller for one radix-2 SDF stage of the 32-point FFT.
// Accepts samples with valid/ready, tracks the position inside each
// 2*DELAY-sample frame, and drives the butterfly mode, shift-register
// enable, twiddle index and registered data/valid one cycle after each
// accept. A flush request drains the feedback shift register at the next
// frame boundary so the last frame's difference terms leave the stage.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   valid_i, ready_o          input handshake (ready_o from state only)
//   data_in_r, data_in_i      input sample
//   flush_i                   drain request pulse (held until serviced)
//   mode_o                    00 hold, 01 fill, 10 butterfly
//   sr_en_o                   feedback shift-register shift enable
//   tw_idx_o                  twiddle index k for W32^k
//   data_out_r, data_out_i    registered sample to butterfly A input
//   valid_o                   stage output valid
//   sop_o                     first output of a frame (only with SDF_CTRL_SOP_EN)
// Build option: define SDF_CTRL_SOP_EN to add the sop_o port.
//
// state    | meaning
// ST_IDLE  | no frame in progress, nothing held in the shift register
// ST_FILL  | first half of a frame: samples loaded into the shift register
// ST_BFLY  | second half of a frame: butterfly with delayed samples
// ST_DRAIN | flushing the shift register for DELAY cycles
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int DELAY = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_in_r,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              flush_i,
    output logic [1:0]        mode_o,
    output logic              sr_en_o,
    output logic [TW_W-1:0]   tw_idx_o,
    output logic [DATA_W-1:0] data_out_r,
    output logic [DATA_W-1:0] data_out_i,
    output logic              valid_o
`ifdef SDF_CTRL_SOP_EN
    ,
    output logic              sop_o
`endif
);

    localparam int          CNT_W   = $clog2(2 * DELAY);
    localparam int          DCNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned TW_STEP = 16 / DELAY;

    stage_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt;
    logic              half;
    logic              wrap;
    logic              accept;
    logic              at_boundary;
    logic              drain_go;
    logic              drain_done;
    logic              pending_q;
    logic              flush_pend_q;
    logic [DCNT_W-1:0] dcnt_q;

    logic [1:0]        mode_d;
    logic              sr_en_d;
    logic              valid_d;
    logic [TW_W-1:0]   tw_d;
    logic [DATA_W-1:0] dr_d;
    logic [DATA_W-1:0] di_d;
`ifdef SDF_CTRL_SOP_EN
    logic              sop_d;
`endif

    fft_sample_cnt #(
        .DELAY (DELAY),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .cnt  (cnt),
        .half (half),
        .wrap (wrap)
    );

    assign at_boundary = ((state_q == ST_IDLE) || (state_q == ST_FILL)) && (cnt == '0);
    assign drain_go    = flush_pend_q && pending_q && (state_q == ST_FILL) && (cnt == '0);
    assign drain_done  = (state_q == ST_DRAIN) && (dcnt_q == '0);

    // Drain wins over a simultaneous valid_i in the entry cycle.
    assign ready_o = (state_q != ST_DRAIN) && !drain_go;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (drain_go) begin
                    state_d = ST_DRAIN;
                end else if (accept) begin
                    state_d = (cnt == CNT_W'(DELAY - 1)) ? ST_BFLY : ST_FILL;
                end
            end
            ST_BFLY: begin
                if (wrap) begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the next cycle; drain outputs are aligned with the
    // cycles spent in ST_DRAIN, everything else follows the accepted sample.
    always_comb begin
        mode_d  = MODE_HOLD;
        sr_en_d = 1'b0;
        valid_d = 1'b0;
        tw_d    = '0;
        dr_d    = data_out_r;
        di_d    = data_out_i;
`ifdef SDF_CTRL_SOP_EN
        sop_d   = 1'b0;
`endif
        if (state_d == ST_DRAIN) begin
            mode_d  = MODE_FILL;
            sr_en_d = 1'b1;
            valid_d = 1'b1;
            dr_d    = '0;
            di_d    = '0;
        end else if (accept) begin
            sr_en_d = 1'b1;
            dr_d    = data_in_r;
            di_d    = data_in_i;
            if (half) begin
                mode_d  = MODE_BFLY;
                valid_d = 1'b1;
                tw_d    = tw_index(32'(cnt - CNT_W'(DELAY)), TW_STEP);
`ifdef SDF_CTRL_SOP_EN
                sop_d   = (cnt == CNT_W'(DELAY));
`endif
            end else begin
                mode_d  = MODE_FILL;
                valid_d = pending_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_o     <= MODE_HOLD;
            sr_en_o    <= 1'b0;
            valid_o    <= 1'b0;
            tw_idx_o   <= '0;
            data_out_r <= '0;
            data_out_i <= '0;
`ifdef SDF_CTRL_SOP_EN
            sop_o      <= 1'b0;
`endif
        end else begin
            mode_o     <= mode_d;
            sr_en_o    <= sr_en_d;
            valid_o    <= valid_d;
            tw_idx_o   <= tw_d;
            data_out_r <= dr_d;
            data_out_i <= di_d;
`ifdef SDF_CTRL_SOP_EN
            sop_o      <= sop_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            dcnt_q       <= '0;
        end else begin
            if (drain_done) begin
                pending_q <= 1'b0;
            end else if (wrap) begin
                pending_q <= 1'b1;
            end

            // A flush with nothing held is dropped at the frame boundary.
            if (drain_done) begin
                flush_pend_q <= 1'b0;
            end else if (flush_i) begin
                flush_pend_q <= 1'b1;
            end else if (at_boundary && !pending_q) begin
                flush_pend_q <= 1'b0;
            end

            if (drain_go) begin
                dcnt_q <= DCNT_W'(DELAY - 1);
            end else if ((state_q == ST_DRAIN) && (dcnt_q != '0)) begin
                dcnt_q <= dcnt_q - DCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid  [4];
    logic [15:0] din_r  [4];
    logic [15:0] din_i  [4];
    logic        flush  [4];
    logic        ready  [4];
    logic [1:0]  mode   [4];
    logic        sr_en  [4];
    logic [3:0]  tw     [4];
    logic [15:0] dout_r [4];
    logic [15:0] dout_i [4];
    logic        vout   [4];
`ifdef SDF_CTRL_SOP_EN
    logic        sop    [4];
`endif

    int total = 0;
    int bad   = 0;

    // Instances: 0 -> DELAY=2, 1 -> DELAY=4, 2 -> DELAY=16, 3 -> DELAY=8
    sdf_stage_ctrl #(.DELAY(2)) u_d2 (
        .clk(clk), .rst(rst), .valid_i(valid[0]), .ready_o(ready[0]),
        .data_in_r(din_r[0]), .data_in_i(din_i[0]), .flush_i(flush[0]),
        .mode_o(mode[0]), .sr_en_o(sr_en[0]), .tw_idx_o(tw[0]),
        .data_out_r(dout_r[0]), .data_out_i(dout_i[0]), .valid_o(vout[0])
`ifdef SDF_CTRL_SOP_EN
        , .sop_o(sop[0])
`endif
    );

    sdf_stage_ctrl #(.DELAY(4)) u_d4 (
        .clk(clk), .rst(rst), .valid_i(valid[1]), .ready_o(ready[1]),
        .data_in_r(din_r[1]), .data_in_i(din_i[1]), .flush_i(flush[1]),
        .mode_o(mode[1]), .sr_en_o(sr_en[1]), .tw_idx_o(tw[1]),
        .data_out_r(dout_r[1]), .data_out_i(dout_i[1]), .valid_o(vout[1])
`ifdef SDF_CTRL_SOP_EN
        , .sop_o(sop[1])
`endif
    );

    sdf_stage_ctrl #(.DELAY(16)) u_d16 (
        .clk(clk), .rst(rst), .valid_i(valid[2]), .ready_o(ready[2]),
        .data_in_r(din_r[2]), .data_in_i(din_i[2]), .flush_i(flush[2]),
        .mode_o(mode[2]), .sr_en_o(sr_en[2]), .tw_idx_o(tw[2]),
        .data_out_r(dout_r[2]), .data_out_i(dout_i[2]), .valid_o(vout[2])
`ifdef SDF_CTRL_SOP_EN
        , .sop_o(sop[2])
`endif
    );

    sdf_stage_ctrl #(.DELAY(8)) u_d8 (
        .clk(clk), .rst(rst), .valid_i(valid[3]), .ready_o(ready[3]),
        .data_in_r(din_r[3]), .data_in_i(din_i[3]), .flush_i(flush[3]),
        .mode_o(mode[3]), .sr_en_o(sr_en[3]), .tw_idx_o(tw[3]),
        .data_out_r(dout_r[3]), .data_out_i(dout_i[3]), .valid_o(vout[3])
`ifdef SDF_CTRL_SOP_EN
        , .sop_o(sop[3])
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed as {mode, sr_en, valid, tw, data_r, data_i}.
    task automatic chk_out(input string tag, input int k, input logic [1:0] m, input logic s,
                           input logic v, input logic [3:0] t, input logic [15:0] dr,
                           input logic [15:0] di);
        check(tag, {mode[k], sr_en[k], vout[k], tw[k], dout_r[k], dout_i[k]},
              {m, s, v, t, dr, di});
    endtask

    task automatic chk_rdy(input string tag, input int k, input logic exp);
        check(tag, 40'(ready[k]), 40'(exp));
    endtask

    task automatic drive(input int k, input logic v, input logic [15:0] r, input logic f);
        valid[k] = v;
        din_r[k] = r;
        din_i[k] = ~r;
        flush[k] = f;
    endtask

    initial begin
        logic [1:0] em [8];
        logic       ev [8];
        logic [3:0] et [8];
        int         p;
        int         sops;

        rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 16'h0000, 1'b0);
        repeat (2) tick;

        // Reset state
        for (int k = 0; k < 4; k++) begin
            chk_out("rst_out", k, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
            chk_rdy("rst_rdy", k, 1'b1);
        end
`ifdef SDF_CTRL_SOP_EN
        check("rst_sop", 40'(sop[3]), 40'(0));
`endif
        rst = 1'b1;
        tick;

        // DELAY=2, continuous samples 1..8
        em = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
        ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        et = '{4'd0, 4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd8};
        for (int n = 1; n <= 8; n++) begin
            drive(0, 1'b1, 16'(n), 1'b0);
            chk_rdy("d2_rdy", 0, 1'b1);
            tick;
            chk_out("d2_out", 0, em[n-1], 1'b1, ev[n-1], et[n-1], 16'(n), ~16'(n));
        end
        drive(0, 1'b0, 16'h0000, 1'b0);
        tick;
        chk_out("d2_gap", 0, 2'd0, 1'b0, 1'b0, 4'd0, 16'd8, ~16'd8);

        // DELAY=16, valid toggling every other cycle
        for (int s = 0; s < 32; s++) begin
            drive(2, 1'b1, 16'(100 + s), 1'b0);
            tick;
            chk_out("d16_acc", 2, (s < 16) ? 2'd1 : 2'd2, 1'b1, (s >= 16),
                    (s >= 16) ? 4'(s - 16) : 4'd0, 16'(100 + s), ~16'(100 + s));
            drive(2, 1'b0, 16'hdead, 1'b0);
            tick;
            chk_out("d16_gap", 2, 2'd0, 1'b0, 1'b0, 4'd0, 16'(100 + s), ~16'(100 + s));
        end

        // DELAY=4, one frame then flush at the boundary
        for (int s = 0; s < 8; s++) begin
            drive(1, 1'b1, 16'(16'h10 + s), 1'b0);
            tick;
            chk_out("d4_f1", 1, (s < 4) ? 2'd1 : 2'd2, 1'b1, (s >= 4),
                    (s >= 4) ? 4'(4 * (s - 4)) : 4'd0, 16'(16'h10 + s), ~16'(16'h10 + s));
        end
        drive(1, 1'b0, 16'h0000, 1'b1);
        chk_rdy("d4_rdy_pre", 1, 1'b1);
        tick;
        chk_out("d4_hold", 1, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0017, ~16'h0017);
        drive(1, 1'b0, 16'h0000, 1'b0);
        chk_rdy("d4_rdy_entry", 1, 1'b0);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk_out("d4_drain", 1, 2'd1, 1'b1, 1'b1, 4'd0, 16'h0000, 16'h0000);
            chk_rdy("d4_rdy_drain", 1, 1'b0);
            tick;
        end
        chk_out("d4_idle", 1, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        chk_rdy("d4_rdy_idle", 1, 1'b1);

        // DELAY=4, flush at cnt=2, valid held high into the boundary
        for (int s = 0; s < 8; s++) begin
            drive(1, 1'b1, 16'(16'h20 + s), (s == 2));
            chk_rdy("d4b_rdy", 1, 1'b1);
            tick;
            chk_out("d4b", 1, (s < 4) ? 2'd1 : 2'd2, 1'b1, (s >= 4),
                    (s >= 4) ? 4'(4 * (s - 4)) : 4'd0, 16'(16'h20 + s), ~16'(16'h20 + s));
        end
        drive(1, 1'b1, 16'h0099, 1'b0);
        chk_rdy("d4b_entry", 1, 1'b0);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk_out("d4b_drain", 1, 2'd1, 1'b1, 1'b1, 4'd0, 16'h0000, 16'h0000);
            chk_rdy("d4b_rdy_drain", 1, 1'b0);
            tick;
        end
        chk_out("d4b_exit", 1, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        chk_rdy("d4b_rdy_exit", 1, 1'b1);
        tick;
        chk_out("d4b_first", 1, 2'd1, 1'b1, 1'b0, 4'd0, 16'h0099, ~16'h0099);

        // DELAY=4, reset at cnt=5
        for (int s = 1; s <= 4; s++) begin
            drive(1, 1'b1, 16'(16'h30 + s), 1'b0);
            tick;
            chk_out("pre_rst", 1, (s < 4) ? 2'd1 : 2'd2, 1'b1, (s == 4), 4'd0,
                    16'(16'h30 + s), ~16'(16'h30 + s));
        end
        drive(1, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        #1;
        chk_out("rst_mid", 1, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        chk_rdy("rst_mid_rdy", 1, 1'b1);
        tick;
        rst = 1'b1;
        for (int s = 0; s < 5; s++) begin
            drive(1, 1'b1, 16'(16'h40 + s), 1'b0);
            tick;
            chk_out("post_rst", 1, (s < 4) ? 2'd1 : 2'd2, 1'b1, (s == 4), 4'd0,
                    16'(16'h40 + s), ~16'(16'h40 + s));
        end
        drive(1, 1'b0, 16'h0000, 1'b0);

        // DELAY=8: flush with nothing pending is dropped, then two frames
        drive(3, 1'b0, 16'h0000, 1'b1);
        tick;
        drive(3, 1'b0, 16'h0000, 1'b0);
        tick;
        chk_rdy("d8_nop_rdy", 3, 1'b1);
        chk_out("d8_nop", 3, 2'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        sops = 0;
        for (int s = 0; s < 32; s++) begin
            p = s % 16;
            drive(3, 1'b1, 16'(200 + s), 1'b0);
            tick;
            chk_out("d8", 3, (p < 8) ? 2'd1 : 2'd2, 1'b1, (p >= 8) || (s >= 16),
                    (p >= 8) ? 4'(2 * (p - 8)) : 4'd0, 16'(200 + s), ~16'(200 + s));
`ifdef SDF_CTRL_SOP_EN
            check("d8_sop", 40'(sop[3]), 40'(p == 8));
            if (sop[3] === 1'b1) sops++;
`endif
        end
        drive(3, 1'b0, 16'h0000, 1'b0);
        chk_rdy("d8_end_rdy", 3, 1'b1);
`ifdef SDF_CTRL_SOP_EN
        check("d8_sop_count", 40'(sops), 40'(2));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
